// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pc_unit_pkg;

    localparam int          CORE_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_HOLD = 3'd3,
        FS_DROP = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_TGT  = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bus: one request outstanding at a time.
interface fetch_pc_unit_if
    import fetch_pc_unit_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_unit_pc_next_mux.sv
// Next-PC selection: hold, sequential +4 (wraps), or redirect target with bit 0 cleared.
module fetch_pc_unit_pc_next_mux
    import fetch_pc_unit_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target,
    input  pc_sel_t         sel,
    output logic [XLEN-1:0] pc_next
);

    // select the next program counter
    always_comb begin
        pc_next = pc;
        case (sel)
            PC_HOLD: pc_next = pc;
            PC_INC:  pc_next = pc + XLEN'(3'd4);
            PC_TGT:  pc_next = {target[XLEN-1:1], 1'b0};
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage and PC register: single-outstanding imem requests, stall hold buffer,
// and branch/jump redirect with IF flush.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              taken,
    input  logic              jump,
    input  logic [XLEN-1:0]   target,
    fetch_pc_unit_if.master   imem,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [31:0]       if_instr,
    output logic              flush
);

    localparam logic [2:0] S_IDLE = FS_IDLE;
    localparam logic [2:0] S_REQ  = FS_REQ;
    localparam logic [2:0] S_WAIT = FS_WAIT;
    localparam logic [2:0] S_HOLD = FS_HOLD;
    localparam logic [2:0] S_DROP = FS_DROP;

    localparam logic [1:0] LD_NONE = 2'd0;
    localparam logic [1:0] LD_MEM  = 2'd1;
    localparam logic [1:0] LD_BUF  = 2'd2;

    logic [2:0]      state_r;
    logic [2:0]      state_nx_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    pc_sel_t         pc_sel_s;
    logic [1:0]      load_sel_s;
    logic            buf_we_s;
    logic [31:0]     buf_instr_r;
    logic [XLEN-1:0] buf_pc_r;
    logic            if_valid_r;
    logic [XLEN-1:0] if_pc_r;
    logic [31:0]     if_instr_r;
    logic            redirect_s;
    logic            req_s;
    logic            accept_s;

    assign redirect_s = taken | jump;
    // a stalled pipeline must not start a new fetch
    assign req_s      = (state_r == S_REQ) & ~stall;
    assign accept_s   = req_s & imem.imem_ready;

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_r;
    assign flush          = redirect_s;
    assign if_valid       = if_valid_r;
    assign if_pc          = if_pc_r;
    assign if_instr       = if_instr_r;

    fetch_pc_unit_pc_next_mux #(.XLEN(XLEN)) u_pc_next_mux (
        .pc      (pc_r),
        .target  (target),
        .sel     (pc_sel_s),
        .pc_next (pc_next_s)
    );

    // fetch FSM next-state, PC select and IF/ID load decisions
    always_comb begin
        state_nx_s = state_r;
        pc_sel_s   = PC_HOLD;
        load_sel_s = LD_NONE;
        buf_we_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                state_nx_s = S_REQ;
                if (redirect_s) pc_sel_s = PC_TGT;
                else            pc_sel_s = PC_HOLD;
            end
            S_REQ: begin
                if (redirect_s) begin
                    pc_sel_s = PC_TGT;
                    // an accepted request still returns a word that must be swallowed
                    if (accept_s) state_nx_s = S_DROP;
                    else          state_nx_s = S_REQ;
                end else if (accept_s) begin
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect_s) begin
                    pc_sel_s = PC_TGT;
                    if (imem.imem_rvalid) state_nx_s = S_REQ;
                    else                  state_nx_s = S_DROP;
                end else if (imem.imem_rvalid && !stall) begin
                    load_sel_s = LD_MEM;
                    pc_sel_s   = PC_INC;
                    state_nx_s = S_REQ;
                end else if (imem.imem_rvalid) begin
                    buf_we_s   = 1'b1;
                    state_nx_s = S_HOLD;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_s) begin
                    pc_sel_s   = PC_TGT;
                    state_nx_s = S_REQ;
                end else if (!stall) begin
                    load_sel_s = LD_BUF;
                    pc_sel_s   = PC_INC;
                    state_nx_s = S_REQ;
                end else begin
                    state_nx_s = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect_s) begin
                    pc_sel_s = PC_TGT;
                    // a response arriving with the new redirect is the one being dropped
                    if (imem.imem_rvalid) state_nx_s = S_REQ;
                    else                  state_nx_s = S_DROP;
                end else if (imem.imem_rvalid) begin
                    state_nx_s = S_REQ;
                end else begin
                    state_nx_s = S_DROP;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // state and program counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_next_s;
        end
    end

    // hold buffer captures a response that arrives while decode is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_instr_r <= NOP_INSTR;
            buf_pc_r    <= RESET_PC;
        end else if (buf_we_s) begin
            buf_instr_r <= imem.imem_rdata;
            buf_pc_r    <= pc_r;
        end
    end

    // IF/ID output registers; a non-stalled cycle without a new word becomes a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_r <= 1'b0;
            if_pc_r    <= RESET_PC;
            if_instr_r <= NOP_INSTR;
        end else if (redirect_s) begin
            if_valid_r <= 1'b0;
            if_instr_r <= NOP_INSTR;
        end else if (load_sel_s == LD_MEM) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= pc_r;
            if_instr_r <= imem.imem_rdata;
        end else if (load_sel_s == LD_BUF) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= buf_pc_r;
            if_instr_r <= buf_instr_r;
        end else if (!stall) begin
            if_valid_r <= 1'b0;
            if_instr_r <= NOP_INSTR;
        end
    end

endmodule
